// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/MRET sequencer: prioritises trap requests, waits for the
// pipeline to drain, commits mepc/mcause/mstatus and redirects fetch.
module prv_trap_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0200,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        mal_s,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        fault_l,
  input  logic        ret,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic [2:0]  mie_bits,
  input  logic        mstatus_mie,
  input  logic [31:0] curr_epc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        pipe_clear,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] npc,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_trap,
  output logic        mstatus_ret,
  output logic        busy
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, REDIRECT, RET} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   cause_q, cause_d;
  logic                int_q, int_d;
  logic [XLEN-1:0]     epc_q, epc_d;
  logic [XLEN-1:0]     npc_d;
  logic                intr_d, insert_pc_d, mepc_we_d, mcause_we_d;
  logic                mstatus_trap_d, mstatus_ret_d;

  logic                exc_any, int_any;
  logic [CODE_W-1:0]   exc_code, int_code;
  logic [2:0]          pend;
  logic [XLEN-1:0]     base, target;

  // Fixed-priority encoders for synchronous exceptions and enabled interrupts
  always_comb begin
    exc_any = fault_insn | mal_insn | illegal_insn | breakpoint | env_m |
              mal_s | mal_l | fault_s | fault_l;
    if      (fault_insn)   exc_code = 4'd1;
    else if (mal_insn)     exc_code = 4'd0;
    else if (illegal_insn) exc_code = 4'd2;
    else if (breakpoint)   exc_code = 4'd3;
    else if (env_m)        exc_code = 4'd11;
    else if (mal_s)        exc_code = 4'd6;
    else if (mal_l)        exc_code = 4'd4;
    else if (fault_s)      exc_code = 4'd7;
    else if (fault_l)      exc_code = 4'd5;
    else                   exc_code = 4'd0;

    pend    = {ext_int & mie_bits[2], soft_int & mie_bits[1], timer_int & mie_bits[0]}
              & {3{mstatus_mie}};
    int_any = |pend;
    if      (pend[2]) int_code = 4'd11;
    else if (pend[1]) int_code = 4'd3;
    else              int_code = 4'd7;
  end

  // Trap target; vectored mode only offsets interrupts
  always_comb begin
    base = {mtvec[XLEN-1:2], 2'b00};
    if (VECTORED_EN && int_q && (mtvec[1:0] == 2'b01))
      target = base + XLEN'({cause_q, 2'b00});
    else
      target = base;
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    int_d          = int_q;
    epc_d          = epc_q;
    npc_d          = npc;
    intr_d         = 1'b0;
    insert_pc_d    = 1'b0;
    mepc_we_d      = 1'b0;
    mcause_we_d    = 1'b0;
    mstatus_trap_d = 1'b0;
    mstatus_ret_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_any || int_any) begin
          state_d = DRAIN;
          cause_d = exc_any ? exc_code : int_code;
          int_d   = !exc_any;
          epc_d   = curr_epc;
          intr_d  = !exc_any;
        end else if (ret) begin
          state_d       = RET;
          insert_pc_d   = 1'b1;
          npc_d         = mepc;
          mstatus_ret_d = 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_clear) begin
          state_d        = COMMIT;
          mepc_we_d      = 1'b1;
          mcause_we_d    = 1'b1;
          mstatus_trap_d = 1'b1;
        end else begin
          intr_d = int_q;
        end
      end
      COMMIT: begin
        state_d     = REDIRECT;
        insert_pc_d = 1'b1;
        npc_d       = target;
      end
      REDIRECT: state_d = IDLE;
      RET:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered alongside the state they belong to
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      int_q        <= 1'b0;
      epc_q        <= '0;
      intr         <= 1'b0;
      insert_pc    <= 1'b0;
      npc          <= RESET_VECTOR;
      mepc_we      <= 1'b0;
      mepc_wdata   <= '0;
      mcause_we    <= 1'b0;
      mcause_wdata <= '0;
      mstatus_trap <= 1'b0;
      mstatus_ret  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      int_q        <= int_d;
      epc_q        <= epc_d;
      intr         <= intr_d;
      insert_pc    <= insert_pc_d;
      npc          <= npc_d;
      mepc_we      <= mepc_we_d;
      mepc_wdata   <= {epc_d[XLEN-1:2], 2'b00};
      mcause_we    <= mcause_we_d;
      mcause_wdata <= {int_d, 27'b0, cause_d};
      mstatus_trap <= mstatus_trap_d;
      mstatus_ret  <= mstatus_ret_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Self-checking bench for prv_trap_sequencer: vector table driven into the DUT,
// CSR commits and fetch redirects matched against a scoreboard.
module tb_prv_trap_sequencer;

  localparam logic [8:0] E_FI = 9'h100, E_MI = 9'h080, E_IL = 9'h040, E_BP = 9'h020,
                         E_EM = 9'h010, E_MS = 9'h008, E_ML = 9'h004, E_FS = 9'h002,
                         E_FL = 9'h001;
  localparam logic [2:0] I_EXT = 3'b100, I_SOFT = 3'b010, I_TIM = 3'b001;
  localparam int K_NONE = 0, K_TRAP = 1, K_RET = 2;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
  logic        mal_s, mal_l, fault_s, fault_l, ret;
  logic        timer_int, soft_int, ext_int, mstatus_mie, pipe_clear;
  logic [2:0]  mie_bits;
  logic [31:0] curr_epc, mtvec, mepc;
  logic        intr, insert_pc, mepc_we, mcause_we, mstatus_trap, mstatus_ret, busy;
  logic [31:0] npc, mepc_wdata, mcause_wdata;

  prv_trap_sequencer dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env_m(env_m), .mal_s(mal_s), .mal_l(mal_l),
    .fault_s(fault_s), .fault_l(fault_l), .ret(ret),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mie_bits(mie_bits), .mstatus_mie(mstatus_mie), .curr_epc(curr_epc),
    .mtvec(mtvec), .mepc(mepc), .pipe_clear(pipe_clear),
    .intr(intr), .insert_pc(insert_pc), .npc(npc),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
    .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
    .mstatus_trap(mstatus_trap), .mstatus_ret(mstatus_ret), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0]  exc;
    logic [2:0]  irq;
    logic [2:0]  mie;
    logic        gie;
    logic        rt;
    logic [31:0] epc;
    logic [31:0] tvec;
    logic [31:0] mepc_in;
    int          drain;
    int          kind;
    logic [31:0] cause;
    logic [31:0] wdata;
    logic [31:0] tgt;
    logic        xintr;
  } vec_t;

  typedef struct { logic [31:0] wdata; logic [31:0] cause; } commit_t;
  typedef struct { logic [31:0] tgt; logic is_ret; } redir_t;

  commit_t cq[$];
  redir_t  rq[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_ins = -1;
  vec_t vecs[13];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic [8:0] exc, logic [2:0] irq, logic [2:0] mie, logic gie,
                              logic rt, logic [31:0] epc, logic [31:0] tvec,
                              logic [31:0] mepc_in, int drain, int kind,
                              logic [31:0] cause, logic [31:0] wdata, logic [31:0] tgt,
                              logic xintr);
    vec_t v;
    v.exc = exc; v.irq = irq; v.mie = mie; v.gie = gie; v.rt = rt; v.epc = epc;
    v.tvec = tvec; v.mepc_in = mepc_in; v.drain = drain; v.kind = kind;
    v.cause = cause; v.wdata = wdata; v.tgt = tgt; v.xintr = xintr;
    return v;
  endfunction

  // Scoreboard consumer: every CSR commit and every fetch redirect must be expected
  always @(negedge CLK) begin
    commit_t ce;
    redir_t  re;
    if (mcause_we || mepc_we || mstatus_trap) begin
      if (cq.size() == 0) chk("unexpected_commit", 32'(mcause_we), 32'd0);
      else begin
        ce = cq.pop_front();
        chk("mepc_wdata", mepc_wdata, ce.wdata);
        chk("mcause_wdata", mcause_wdata, ce.cause);
        chk("commit_strobes", {29'd0, mepc_we, mcause_we, mstatus_trap}, 32'd7);
      end
    end
    if (insert_pc) begin
      last_ins = cyc;
      if (rq.size() == 0) chk("unexpected_insert_pc", 32'(insert_pc), 32'd0);
      else begin
        re = rq.pop_front();
        chk("npc", npc, re.tgt);
        chk("mstatus_ret", 32'(mstatus_ret), 32'(re.is_ret));
      end
    end else if (mstatus_ret) begin
      chk("stray_mstatus_ret", 32'(mstatus_ret), 32'd0);
    end
  end

  task automatic clear_reqs();
    {fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_s, mal_l, fault_s, fault_l} = '0;
    {ext_int, soft_int, timer_int} = '0;
    ret = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int c, n;
    @(negedge CLK);
    c = cyc;
    {fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_s, mal_l, fault_s, fault_l} = v.exc;
    {ext_int, soft_int, timer_int} = v.irq;
    mie_bits = v.mie; mstatus_mie = v.gie; ret = v.rt;
    curr_epc = v.epc; mtvec = v.tvec; mepc = v.mepc_in;
    pipe_clear = (v.drain == 0);
    if (v.kind == K_TRAP) begin
      cq.push_back('{wdata: v.wdata, cause: v.cause});
      rq.push_back('{tgt: v.tgt, is_ret: 1'b0});
    end else if (v.kind == K_RET) begin
      rq.push_back('{tgt: v.mepc_in, is_ret: 1'b1});
    end
    @(negedge CLK);
    clear_reqs();
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.kind != K_NONE));
    chk($sformatf("v%0d_intr", idx), 32'(intr), 32'(v.xintr));
    for (int i = 0; i < v.drain; i++) begin
      @(negedge CLK);
      chk($sformatf("v%0d_drain_intr", idx), 32'(intr), 32'(v.xintr));
      chk($sformatf("v%0d_drain_nowrite", idx), {30'd0, mepc_we, mcause_we}, 32'd0);
    end
    pipe_clear = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("v%0d_idle_timeout", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_sb_empty", idx), 32'(cq.size() + rq.size()), 32'd0);
    if (v.kind == K_TRAP) chk($sformatf("v%0d_latency", idx), 32'(last_ins - c), 32'(3 + v.drain));
    if (v.kind == K_RET)  chk($sformatf("v%0d_latency", idx), 32'(last_ins - c), 32'd1);
    cq.delete();
    rq.delete();
  endtask

  initial begin
    clear_reqs();
    mie_bits = 3'b000; mstatus_mie = 1'b0; curr_epc = '0; mtvec = '0; mepc = '0;
    pipe_clear = 1'b1;

    //            exc        irq          mie     gie rt  epc           mtvec         mepc          dr kind    cause          wdata         npc           intr
    vecs[0]  = mk(E_IL,      3'b0,        3'b000, 0, 0, 32'h100,      32'h400,      32'h0,        0, K_TRAP, 32'h2,         32'h100,      32'h400,      0);
    vecs[1]  = mk(E_ML|E_FI, 3'b0,        3'b000, 0, 0, 32'h204,      32'h400,      32'h0,        0, K_TRAP, 32'h1,         32'h204,      32'h400,      0);
    vecs[2]  = mk(E_EM,      I_TIM,       3'b001, 1, 0, 32'h300,      32'h400,      32'h0,        0, K_TRAP, 32'hB,         32'h300,      32'h400,      0);
    vecs[3]  = mk(9'h0,      I_EXT|I_TIM, 3'b111, 1, 0, 32'h50,       32'h401,      32'h0,        0, K_TRAP, 32'h8000_000B, 32'h50,       32'h42C,      1);
    vecs[4]  = mk(9'h0,      I_TIM,       3'b001, 1, 0, 32'h60,       32'h401,      32'h0,        4, K_TRAP, 32'h8000_0007, 32'h60,       32'h41C,      1);
    vecs[5]  = mk(9'h0,      3'b0,        3'b000, 0, 1, 32'h0,        32'h400,      32'h2000,     0, K_RET,  32'h0,         32'h0,        32'h2000,     0);
    vecs[6]  = mk(E_BP,      3'b0,        3'b000, 0, 1, 32'h88,       32'h800,      32'h2000,     0, K_TRAP, 32'h3,         32'h88,       32'h800,      0);
    vecs[7]  = mk(9'h0,      I_TIM,       3'b001, 0, 0, 32'h70,       32'h400,      32'h0,        0, K_NONE, 32'h0,         32'h0,        32'h0,        0);
    vecs[8]  = mk(9'h0,      I_SOFT|I_TIM,3'b011, 1, 0, 32'h74,       32'h400,      32'h0,        1, K_TRAP, 32'h8000_0003, 32'h74,       32'h400,      1);
    vecs[9]  = mk(E_MS|E_FL, 3'b0,        3'b000, 0, 0, 32'h103,      32'h403,      32'h0,        0, K_TRAP, 32'h6,         32'h100,      32'h400,      0);
    vecs[10] = mk(E_FS,      3'b0,        3'b000, 0, 0, 32'h108,      32'h401,      32'h0,        2, K_TRAP, 32'h7,         32'h108,      32'h400,      0);
    vecs[11] = mk(9'h0,      I_EXT,       3'b100, 1, 0, 32'h10C,      32'hFFFF_FFF1,32'h0,        0, K_TRAP, 32'h8000_000B, 32'h10C,      32'h0000_001C,1);
    vecs[12] = mk(9'h0,      I_EXT,       3'b010, 1, 0, 32'h110,      32'h400,      32'h0,        0, K_NONE, 32'h0,         32'h0,        32'h0,        0);

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_insert_pc", 32'(insert_pc), 32'd0);
    chk("rst_npc", npc, 32'h0000_0200);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_strobes", {28'd0, mepc_we, mcause_we, mstatus_trap, mstatus_ret}, 32'd0);
    RST = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset while in COMMIT aborts the redirect and restores npc
    @(negedge CLK);
    illegal_insn = 1'b1; curr_epc = 32'h140; mtvec = 32'h600; pipe_clear = 1'b1;
    cq.push_back('{wdata: 32'h140, cause: 32'h2});
    @(negedge CLK);
    clear_reqs();
    chk("abort_drain_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    chk("abort_in_commit", 32'(mcause_we), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_insert_pc", 32'(insert_pc), 32'd0);
    chk("abort_npc", npc, 32'h0000_0200);
    chk("abort_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_no_redirect", 32'(insert_pc | busy), 32'd0);
    chk("abort_sb_empty", 32'(cq.size() + rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
- Controller between the hazard unit and the machine-mode CSR file.
- Prioritises exception and interrupt requests and waits for the pipeline to drain.
- Commits trap state (mepc, mcause, mstatus.MIE/MPIE), then redirects fetch via npc/insert_pc.
- Also sequences MRET: restores mstatus and redirects fetch to mepc.

Parameters:
- RESET_VECTOR, 32'h0000_0200, npc value held while no redirect is pending.
- VECTORED_EN, 1, when 1 and mtvec[1:0]==2'b01, interrupt targets are (mtvec & ~3) + 4*code; exceptions always target mtvec & ~3.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_s, mal_l, fault_s, fault_l  in  1 each  exception requests from hazard unit.
- ret  in  1  MRET committed.
- timer_int, soft_int, ext_int  in  1 each  raw interrupt lines.
- mie_bits  in  3  {MEIE, MSIE, MTIE} enables.
- mstatus_mie  in  1  global interrupt enable.
- curr_epc  in  32  PC of the faulting or interrupted instruction.
- mtvec  in  32  trap vector CSR.
- mepc  in  32  current mepc CSR.
- pipe_clear  in  1  pipeline fully drained.
- intr  out  1  interrupt accepted; hazard unit must flush.
- insert_pc  out  1  one-cycle fetch redirect strobe.
- npc  out  32  redirect target.
- mepc_we  out  1  write strobe; mepc_wdata  out  32.
- mcause_we  out  1  write strobe; mcause_wdata  out  32  {int_bit, 27'b0, code[3:0]}.
- mstatus_trap  out  1  strobe: MPIE<=MIE, MIE<=0.
- mstatus_ret  out  1  strobe: MIE<=MPIE, MPIE<=1.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, DRAIN, COMMIT, REDIRECT, RET.
- Reset: state=IDLE; intr, insert_pc, all strobes and busy=0; npc=RESET_VECTOR; latched cause=0; latched epc=0. A reset in any state aborts the sequence; no partial CSR write after reset.
- Interrupt pending: pend = {ext_int&MEIE, soft_int&MSIE, timer_int&MTIE}, valid only if mstatus_mie=1.
- Exception priority (code): fault_insn(1) > mal_insn(0) > illegal_insn(2) > breakpoint(3) > env_m(11) > mal_s(6) > mal_l(4) > fault_s(7) > fault_l(5).
- Interrupt priority: ext(11) > soft(3) > timer(7).
- Exceptions beat interrupts in the same cycle; any exception or interrupt beats ret in the same cycle.
- IDLE, exception or valid interrupt: latch code, int_bit and curr_epc; go to DRAIN.
- IDLE, ret only: go to RET.
- IDLE, otherwise: stay.
- DRAIN: intr=1 iff latched int_bit. Stay until pipe_clear=1, then go to COMMIT. New requests are ignored.
- COMMIT (1 cycle): mepc_we=1 with mepc_wdata=latched epc & ~3; mcause_we=1; mstatus_trap=1. Compute target; go to REDIRECT.
- REDIRECT (1 cycle): insert_pc=1, npc=target; return to IDLE.
- RET (1 cycle): insert_pc=1, npc=mepc; mstatus_ret=1; return to IDLE.
- Latency:
  - Trap request to insert_pc = 3 cycles when pipe_clear is already high on entry to DRAIN; each extra cycle pipe_clear stays low adds one cycle.
  - ret to insert_pc = 1 cycle.
- npc holds its last driven value outside REDIRECT and RET.
- Vector arithmetic is 32-bit unsigned; target wraps modulo 2^32.
- A request held high across the return to IDLE is treated as a new trap; the hazard unit must deassert it after insert_pc.

Test Plan:
- Reset, then illegal_insn=1 with curr_epc=32'h100, mtvec=32'h400, pipe_clear=1 -> COMMIT: mepc_wdata=32'h100, mcause_wdata=32'h2, mstatus_trap=1; next cycle insert_pc=1, npc=32'h400.
- mal_l and fault_insn asserted together -> mcause code 1. Env_m plus timer_int with MTIE=1 and mstatus_mie=1 -> mcause=32'hB, intr stays 0.
- ext_int and timer_int, enables set, mtvec=32'h401, VECTORED_EN=1 -> intr=1 in DRAIN; mcause=32'h8000_000B; npc=32'h42C.
- Interrupt with pipe_clear held low 4 cycles -> DRAIN for 4 cycles with intr=1, no CSR strobes; insert_pc 2 cycles after pipe_clear rises.
- ret with mepc=32'h2000 -> next cycle insert_pc=1, npc=32'h2000, mstatus_ret=1. ret together with breakpoint -> trap path, mcause=3.
- RST asserted in COMMIT -> next cycle state=IDLE, no insert_pc, npc=RESET_VECTOR. timer_int with mstatus_mie=0 -> no response, busy stays 0.
